// File: rtl/pool_game_if.sv
// Signal bundle between the collision logic, the game controller and the HUD.
// The master side drives the table events; the slave side is the controller.
interface pool_game_if #(
  parameter int NUM_BALLS = 3,
  parameter int SCORE_W   = 8
);
  logic                     shotFired;
  logic                     cueStopped;
  logic [NUM_BALLS-1:0]     ballStopped;
  logic                     cueHoleHit;
  logic [NUM_BALLS-1:0]     ballHoleHit;
  logic [3*NUM_BALLS-1:0]   ballHoleNum;
  logic                     cueShow;
  logic [NUM_BALLS-1:0]     ballShow;
  logic                     drawLine;
  logic [2:0]               holeNumToHit;
  logic [3:0]               level;
  logic [SCORE_W-1:0]       score;
  logic [SCORE_W-1:0]       attempts;
  logic                     resetGameN;
  logic                     gameFinished;
  logic                     gameWon;

  modport master (
    output shotFired, cueStopped, ballStopped, cueHoleHit, ballHoleHit, ballHoleNum,
    input  cueShow, ballShow, drawLine, holeNumToHit, level, score, attempts,
           resetGameN, gameFinished, gameWon
  );

  modport slave (
    input  shotFired, cueStopped, ballStopped, cueHoleHit, ballHoleHit, ballHoleNum,
    output cueShow, ballShow, drawLine, holeNumToHit, level, score, attempts,
           resetGameN, gameFinished, gameWon
  );
endinterface

// File: rtl/pool_game_controller.sv
// Shot-phase referee for a cue ball plus NUM_BALLS object balls: scoring, level
// targets, combo bonus, re-rack and win/lose, all outputs registered.
module pool_game_controller #(
  parameter int NUM_BALLS      = 3,
  parameter int NUM_LEVELS     = 10,
  parameter int ANY_HOLE_LEVEL = 7,
  parameter int ATTEMPTS_INIT  = 8,
  parameter int HIT_SCORE      = 5,
  parameter int FOUL_SCORE     = 1,
  parameter int COMBO_BONUS    = 3,
  parameter int SCORE_W        = 8
) (
  input  logic      clk,
  input  logic      reset,
  pool_game_if.slave bus
);
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  typedef enum logic [1:0] {ST_AIM, ST_ROLL, ST_SETTLE, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d, attempts_q, attempts_d;
  logic [3:0]           level_q, level_d;
  logic [2:0]           hole_q, hole_d;
  logic [1:0]           combo_q, combo_d;
  logic                 cue_show_q, cue_show_d;
  logic [NUM_BALLS-1:0] ball_show_q, ball_show_d;
  logic                 draw_line_q, draw_line_d;
  logic                 reset_game_n_q, reset_game_n_d;
  logic                 finished_q, finished_d;
  logic                 won_q, won_d;
  logic                 cue_pot_q, cue_pot_d;

  logic all_stopped, live, shot_ok, cue_evt;
  int   n_correct, n_foul, score_i, level_i, combo_i, hole_i;

  always_comb begin
    all_stopped = !cue_show_q || bus.cueStopped;
    for (int i = 0; i < NUM_BALLS; i++)
      all_stopped = all_stopped && (!ball_show_q[i] || bus.ballStopped[i]);
  end

  always_comb begin
    state_d        = state_q;
    attempts_d     = attempts_q;
    cue_show_d     = cue_show_q;
    ball_show_d    = ball_show_q;
    reset_game_n_d = 1'b1;
    finished_d     = finished_q;
    won_d          = won_q;
    n_correct      = 0;
    n_foul         = 0;
    cue_evt        = 1'b0;
    live           = (state_q == ST_AIM) || (state_q == ST_ROLL);
    shot_ok        = (state_q == ST_AIM) && bus.shotFired && all_stopped && (attempts_q != '0);

    // Pocket events judge against the target held before this cycle's level change.
    if (live) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (bus.ballHoleHit[i] && ball_show_q[i]) begin
          ball_show_d[i] = 1'b0;
          if (hole_q == 3'd0 || bus.ballHoleNum[3*i +: 3] == hole_q) n_correct++;
          else n_foul++;
        end
      end
      if (bus.cueHoleHit && cue_show_q) begin
        cue_show_d = 1'b0;
        cue_evt    = 1'b1;
        n_foul++;
      end
    end

    score_i = int'(score_q) + HIT_SCORE * n_correct - FOUL_SCORE * n_foul;
    if (score_i < 0) score_i = 0;
    if (score_i > SCORE_MAX) score_i = SCORE_MAX;

    level_i = int'(level_q) + n_correct;
    if (level_i > NUM_LEVELS) begin
      level_i = NUM_LEVELS;
      won_d   = 1'b1;
    end
    hole_i = (level_i < ANY_HOLE_LEVEL) ? ((level_i - 1) % 6) + 1 : 0;

    combo_i = (shot_ok ? 0 : int'(combo_q)) + n_correct;
    if (combo_i > 3) combo_i = 3;
    cue_pot_d = (shot_ok ? 1'b0 : cue_pot_q) | cue_evt;

    case (state_q)
      ST_AIM: begin
        if (shot_ok) begin
          attempts_d = attempts_q - SCORE_W'(1);
          state_d    = ST_ROLL;
        end
      end
      ST_ROLL: begin
        if (all_stopped) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (combo_q >= 2'd2) begin
          score_i = int'(score_q) + COMBO_BONUS;
          if (score_i > SCORE_MAX) score_i = SCORE_MAX;
        end
        if (cue_pot_q || ball_show_q == '0) begin
          reset_game_n_d = 1'b0;
          cue_show_d     = 1'b1;
          ball_show_d    = '1;
        end
        if (won_q || attempts_q == '0) begin
          state_d    = ST_DONE;
          finished_d = 1'b1;
        end else begin
          state_d = ST_AIM;
        end
      end
      default: ;
    endcase

    score_d     = score_i[SCORE_W-1:0];
    level_d     = level_i[3:0];
    hole_d      = hole_i[2:0];
    combo_d     = combo_i[1:0];
    draw_line_d = (state_d == ST_AIM) && all_stopped;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_AIM;
      score_q        <= '0;
      attempts_q     <= SCORE_W'(ATTEMPTS_INIT);
      level_q        <= 4'd1;
      hole_q         <= 3'd1;
      combo_q        <= 2'd0;
      cue_show_q     <= 1'b1;
      ball_show_q    <= '1;
      draw_line_q    <= 1'b0;
      reset_game_n_q <= 1'b0;
      finished_q     <= 1'b0;
      won_q          <= 1'b0;
      cue_pot_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      attempts_q     <= attempts_d;
      level_q        <= level_d;
      hole_q         <= hole_d;
      combo_q        <= combo_d;
      cue_show_q     <= cue_show_d;
      ball_show_q    <= ball_show_d;
      draw_line_q    <= draw_line_d;
      reset_game_n_q <= reset_game_n_d;
      finished_q     <= finished_d;
      won_q          <= won_d;
      cue_pot_q      <= cue_pot_d;
    end
  end

  assign bus.cueShow      = cue_show_q;
  assign bus.ballShow     = ball_show_q;
  assign bus.drawLine     = draw_line_q;
  assign bus.holeNumToHit = hole_q;
  assign bus.level        = level_q;
  assign bus.score        = score_q;
  assign bus.attempts     = attempts_q;
  assign bus.resetGameN   = reset_game_n_q;
  assign bus.gameFinished = finished_q;
  assign bus.gameWon      = won_q;
endmodule

// File: tb/tb_pool_game_controller.sv
// Directed bench for pool_game_controller: walks reset, scoring, combo, fouls,
// re-rack, loss by attempts and a full win, checking against hand-computed values.
module tb_pool_game_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pool_game_if #(.NUM_BALLS(3), .SCORE_W(8)) bus ();

  pool_game_controller #(
    .NUM_BALLS(3), .NUM_LEVELS(10), .ANY_HOLE_LEVEL(7), .ATTEMPTS_INIT(8),
    .HIT_SCORE(5), .FOUL_SCORE(1), .COMBO_BONUS(3), .SCORE_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire();
    bus.shotFired = 1'b1;
    tick();
    bus.shotFired = 1'b0;
  endtask

  task automatic pocket(input logic cue, input logic [2:0] hit, input logic [8:0] nums);
    bus.cueHoleHit  = cue;
    bus.ballHoleHit = hit;
    bus.ballHoleNum = nums;
    tick();
    bus.cueHoleHit  = 1'b0;
    bus.ballHoleHit = 3'b000;
  endtask

  task automatic settle();
    bus.cueStopped  = 1'b1;
    bus.ballStopped = 3'b111;
    tick();
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    bus.shotFired   = 1'b0;
    bus.cueStopped  = 1'b1;
    bus.ballStopped = 3'b111;
    bus.cueHoleHit  = 1'b0;
    bus.ballHoleHit = 3'b000;
    bus.ballHoleNum = 9'd0;
    tick();
    tick();
    chk("rst_attempts", 32'(bus.attempts), 8);
    chk("rst_level", 32'(bus.level), 1);
    chk("rst_hole", 32'(bus.holeNumToHit), 1);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_show", 32'({bus.cueShow, bus.ballShow}), 15);
    chk("rst_rerack_low", 32'(bus.resetGameN), 0);
    chk("rst_finished", 32'({bus.gameFinished, bus.gameWon}), 0);

    reset = 1'b0;
    tick();
    chk("rerack_high", 32'(bus.resetGameN), 1);
    chk("aim_drawline", 32'(bus.drawLine), 1);

    // shot refused while a ball is moving
    bus.ballStopped = 3'b101;
    fire();
    chk("moving_attempts", 32'(bus.attempts), 8);
    chk("moving_drawline", 32'(bus.drawLine), 0);
    bus.ballStopped = 3'b111;
    tick();
    chk("stopped_drawline", 32'(bus.drawLine), 1);

    // shot 1: ball0 into hole 1
    fire();
    chk("s1_attempts", 32'(bus.attempts), 7);
    chk("s1_drawline", 32'(bus.drawLine), 0);
    bus.cueStopped = 1'b0;
    pocket(1'b0, 3'b001, {3'd0, 3'd0, 3'd1});
    chk("s1_score", 32'(bus.score), 5);
    chk("s1_level", 32'(bus.level), 2);
    chk("s1_hole", 32'(bus.holeNumToHit), 2);
    chk("s1_show", 32'(bus.ballShow), 6);
    fire();
    chk("roll_shot_ignored", 32'(bus.attempts), 7);
    settle();
    chk("s1_no_rerack", 32'(bus.resetGameN), 1);
    chk("s1_show_kept", 32'(bus.ballShow), 6);
    chk("s1_score_settle", 32'(bus.score), 5);
    chk("s1_back_aim", 32'(bus.drawLine), 1);

    // shot 2: two correct pockets in one cycle, table cleared
    fire();
    chk("s2_attempts", 32'(bus.attempts), 6);
    bus.cueStopped = 1'b0;
    pocket(1'b0, 3'b110, {3'd2, 3'd2, 3'd0});
    chk("s2_score", 32'(bus.score), 15);
    chk("s2_level", 32'(bus.level), 4);
    chk("s2_hole", 32'(bus.holeNumToHit), 4);
    chk("s2_show", 32'(bus.ballShow), 0);
    bus.cueStopped = 1'b1;
    tick();
    chk("s2_pre_settle_score", 32'(bus.score), 15);
    tick();
    chk("s2_combo_score", 32'(bus.score), 18);
    chk("s2_rerack_low", 32'(bus.resetGameN), 0);
    chk("s2_rerack_show", 32'({bus.cueShow, bus.ballShow}), 15);
    tick();
    chk("s2_rerack_high", 32'(bus.resetGameN), 1);

    // reset in the middle of a roll
    fire();
    chk("s3_attempts", 32'(bus.attempts), 5);
    bus.cueStopped = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("midroll_attempts", 32'(bus.attempts), 8);
    chk("midroll_score", 32'(bus.score), 0);
    chk("midroll_level", 32'(bus.level), 1);
    chk("midroll_hole", 32'(bus.holeNumToHit), 1);
    chk("midroll_rerack", 32'(bus.resetGameN), 0);
    reset = 1'b0;
    bus.cueStopped = 1'b1;
    tick();
    chk("midroll_aim", 32'({bus.resetGameN, bus.drawLine}), 3);

    // cue pocket plus wrong-hole ball at score 0
    fire();
    bus.cueStopped = 1'b0;
    pocket(1'b1, 3'b100, {3'd3, 3'd0, 3'd0});
    chk("foul_score", 32'(bus.score), 0);
    chk("foul_show", 32'({bus.cueShow, bus.ballShow}), 3);
    chk("foul_level", 32'(bus.level), 1);
    settle();
    chk("foul_rerack_low", 32'(bus.resetGameN), 0);
    chk("foul_rerack_show", 32'({bus.cueShow, bus.ballShow}), 15);
    tick();
    chk("foul_rerack_high", 32'(bus.resetGameN), 1);

    // remaining seven shots with no pockets
    for (int k = 0; k < 7; k++) begin
      fire();
      chk("loss_attempts", 32'(bus.attempts), 32'(6 - k));
      bus.cueStopped = 1'b0;
      tick();
      settle();
    end
    chk("loss_finished", 32'({bus.gameFinished, bus.gameWon}), 2);
    chk("loss_drawline", 32'(bus.drawLine), 0);
    fire();
    chk("done_attempts", 32'(bus.attempts), 0);
    chk("done_sticky", 32'(bus.gameFinished), 1);

    // full win from a fresh rack
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fire();
    bus.cueStopped = 1'b0;
    pocket(1'b0, 3'b111, {3'd1, 3'd1, 3'd1});
    settle();
    chk("winA_score", 32'(bus.score), 18);
    chk("winA_hole", 32'(bus.holeNumToHit), 4);
    fire();
    bus.cueStopped = 1'b0;
    pocket(1'b0, 3'b111, {3'd4, 3'd4, 3'd4});
    chk("winB_hole_any", 32'(bus.holeNumToHit), 0);
    settle();
    chk("winB_score", 32'(bus.score), 36);
    fire();
    bus.cueStopped = 1'b0;
    pocket(1'b0, 3'b111, {3'd5, 3'd5, 3'd5});
    settle();
    chk("winC_score", 32'(bus.score), 54);
    chk("winC_level", 32'(bus.level), 10);
    fire();
    bus.cueStopped = 1'b0;
    pocket(1'b0, 3'b001, {3'd0, 3'd0, 3'd2});
    chk("winD_won", 32'({bus.gameFinished, bus.gameWon}), 1);
    chk("winD_level_hold", 32'(bus.level), 10);
    chk("winD_score", 32'(bus.score), 59);
    settle();
    chk("win_finished", 32'({bus.gameFinished, bus.gameWon}), 3);
    chk("win_attempts", 32'(bus.attempts), 4);
    chk("win_drawline", 32'(bus.drawLine), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
